// File: rtl/key_debounce_if.sv
// Signal bundle between the key debouncer and user logic.
// The debouncer takes the slave side; the key pin driver and consumers take the master side.
interface key_debounce_if;
  logic       key_n;
  logic       key_state;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  modport master (
    output key_n,
    input  key_state,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  press_cnt
  );

  modport slave (
    input  key_n,
    output key_state,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output press_cnt
  );
endinterface

// File: rtl/key_debounce.sv
// Debounced push-button front end: two-flop synchroniser, bounce filter FSM, strobes, press counter.
// Define KEY_LONG_PRESS_EN to build the long-press counter and long_pulse strobe.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input logic           clk,
  input logic           rst,
  key_debounce_if.slave kb
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_FILT = 2'd1;
  localparam logic [1:0] DOWN       = 2'd2;
  localparam logic [1:0] REL_FILT   = 2'd3;

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic        sync_q1;
  logic        sync_q2;
  logic        key_sync;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] deb_q;
  logic [31:0] deb_d;
  logic [31:0] deb_inc;
  logic        press_hit;
  logic        rel_hit;

  logic        key_state_q;
  logic        press_pulse_q;
  logic        release_pulse_q;
  logic [7:0]  press_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= ~kb.key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign key_sync = sync_q2;

  // The sample that moves IDLE/DOWN into a filter state counts as the first
  // stable cycle, so acceptance happens once the incremented count hits the last value.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    deb_inc   = deb_q + 32'd1;
    press_hit = 1'b0;
    rel_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_sync) begin
          state_d = PRESS_FILT;
          deb_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (!key_sync) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d   = DOWN;
          deb_d     = '0;
          press_hit = 1'b1;
        end else begin
          deb_d = deb_inc;
        end
      end
      DOWN: begin
        if (!key_sync) begin
          state_d = REL_FILT;
          deb_d   = '0;
        end
      end
      REL_FILT: begin
        if (key_sync) begin
          state_d = DOWN;
          deb_d   = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d = IDLE;
          deb_d   = '0;
          rel_hit = 1'b1;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      deb_q           <= '0;
      key_state_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      deb_q           <= deb_d;
      press_pulse_q   <= press_hit;
      release_pulse_q <= rel_hit;
      if (press_hit) begin
        key_state_q <= 1'b1;
        press_cnt_q <= press_cnt_q + 8'd1;
      end else if (rel_hit) begin
        key_state_q <= 1'b0;
      end
    end
  end

  assign kb.key_state     = key_state_q;
  assign kb.press_pulse   = press_pulse_q;
  assign kb.release_pulse = release_pulse_q;
  assign kb.press_cnt     = press_cnt_q;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [31:0] LONG_SAT  = 32'(LONG_CYCLES);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CYCLES - 1);

  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("key_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic [31:0] long_q;
  logic [31:0] long_d;
  logic        long_hit;
  logic        long_pulse_q;

  // Bouncing between DOWN and REL_FILT keeps the count running; only a fresh
  // press acceptance restarts it. A release accepted on the threshold cycle wins.
  always_comb begin
    long_d   = long_q;
    long_hit = 1'b0;
    if (press_hit) begin
      long_d = '0;
    end else if (state_q == DOWN || state_q == REL_FILT) begin
      if (long_q != LONG_SAT) begin
        long_d = long_q + 32'd1;
      end
      long_hit = (long_q != LONG_SAT) && (long_d == LONG_LAST) && !rel_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      long_q       <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_pulse_q <= long_hit;
    end
  end

  assign kb.long_pulse = long_pulse_q;
`else
  // LONG_CYCLES has no effect in this build.
  if (LONG_CYCLES == 0) begin : g_long_unused
  end

  assign kb.long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=16, LONG_CYCLES=100.
// Long-press expectations follow KEY_LONG_PRESS_EN as seen by this compile.
module tb_key_debounce;

`ifdef KEY_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_press;
  int   n_release;
  int   n_long;
  int   last_press_edge;
  int   last_release_edge;
  int   last_long_edge;
  int   k;
  int   r;
  int   base;

  key_debounce_if kb ();

  key_debounce #(
    .DEBOUNCE_CYCLES(16),
    .LONG_CYCLES    (100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kb (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records how many strobes occurred and at which edge.
  initial begin
    n_press = 0; n_release = 0; n_long = 0;
    last_press_edge = -1; last_release_edge = -1; last_long_edge = -1;
  end
  always @(posedge clk) begin
    #1;
    if (kb.press_pulse === 1'b1) begin n_press++; last_press_edge = cyc; end
    if (kb.release_pulse === 1'b1) begin n_release++; last_release_edge = cyc; end
    if (kb.long_pulse === 1'b1) begin n_long++; last_long_edge = cyc; end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    kb.key_n = 1'b1;
    rst = 1'b0;
    step(3);
    chk("rst_key_state", 32'(kb.key_state), 0);
    chk("rst_press_pulse", 32'(kb.press_pulse), 0);
    chk("rst_release_pulse", 32'(kb.release_pulse), 0);
    chk("rst_long_pulse", 32'(kb.long_pulse), 0);
    chk("rst_press_cnt", 32'(kb.press_cnt), 0);
    rst = 1'b1;
    step(3);

    // Clean press: 50 cycles low, press strobe on edge k+18.
    k = cyc;
    kb.key_n = 1'b0;
    step(17);
    chk("clean_pre_state", 32'(kb.key_state), 0);
    chk("clean_pre_pulse", 32'(kb.press_pulse), 0);
    step(1);
    chk("clean_press_pulse", 32'(kb.press_pulse), 1);
    chk("clean_press_state", 32'(kb.key_state), 1);
    chk("clean_press_cnt", 32'(kb.press_cnt), 1);
    chk("clean_press_edge", last_press_edge, k + 18);
    step(1);
    chk("clean_press_width", 32'(kb.press_pulse), 0);
    step(31);
    k = cyc;
    kb.key_n = 1'b1;
    step(17);
    chk("clean_rel_pre_state", 32'(kb.key_state), 1);
    chk("clean_rel_pre_pulse", 32'(kb.release_pulse), 0);
    step(1);
    chk("clean_release_pulse", 32'(kb.release_pulse), 1);
    chk("clean_release_state", 32'(kb.key_state), 0);
    chk("clean_release_edge", last_release_edge, k + 18);
    step(1);
    chk("clean_release_width", 32'(kb.release_pulse), 0);
    chk("clean_no_long", n_long, 0);
    chk("clean_n_press", n_press, 1);

    // Shortest accepted press: exactly 16 low cycles.
    k = cyc;
    kb.key_n = 1'b0;
    step(16);
    kb.key_n = 1'b1;
    step(24);
    chk("min_press_edge", last_press_edge, k + 18);
    chk("min_press_cnt", 32'(kb.press_cnt), 2);
    chk("min_release_edge", last_release_edge, k + 34);
    chk("min_n_release", n_release, 2);

    // Bounce rejection: ten 15-cycle low windows.
    repeat (10) begin
      kb.key_n = 1'b0;
      step(15);
      kb.key_n = 1'b1;
      step(15);
    end
    chk("bounce_n_press", n_press, 2);
    chk("bounce_n_release", n_release, 2);
    chk("bounce_state", 32'(kb.key_state), 0);
    chk("bounce_press_cnt", 32'(kb.press_cnt), 2);

    // Long press: 200 cycles low with a 10-cycle release bounce inside.
    k = cyc;
    kb.key_n = 1'b0;
    step(50);
    kb.key_n = 1'b1;
    step(10);
    kb.key_n = 1'b0;
    step(140);
    chk("long_press_edge", last_press_edge, k + 18);
    chk("long_n_press", n_press, 3);
    chk("long_no_release", n_release, 2);
    chk("long_state_held", 32'(kb.key_state), 1);
    chk("long_n_long", n_long, EXP_LONG);
    if (EXP_LONG == 1) chk("long_edge", last_long_edge, k + 18 + 99);
    kb.key_n = 1'b1;
    k = cyc;
    step(30);
    chk("long_release_edge", last_release_edge, k + 18);
    chk("long_n_long_after", n_long, EXP_LONG);

    // Reset 30 cycles into a held press.
    k = cyc;
    kb.key_n = 1'b0;
    step(30);
    rst = 1'b0;
    step(3);
    chk("midrst_state", 32'(kb.key_state), 0);
    chk("midrst_cnt", 32'(kb.press_cnt), 0);
    chk("midrst_press_pulse", 32'(kb.press_pulse), 0);
    chk("midrst_release_pulse", 32'(kb.release_pulse), 0);
    rst = 1'b1;
    r = cyc;
    step(25);
    chk("midrst_repress_edge", last_press_edge, r + 18);
    chk("midrst_repress_cnt", 32'(kb.press_cnt), 1);
    chk("midrst_n_press", n_press, 5);
    chk("midrst_no_release", n_release, 3);
    kb.key_n = 1'b1;
    step(30);
    chk("midrst_n_release", n_release, 4);

    // Counter wrap: 256 clean presses from a cleared counter.
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);
    base = n_press;
    repeat (255) begin
      kb.key_n = 1'b0;
      step(20);
      kb.key_n = 1'b1;
      step(20);
    end
    chk("wrap_cnt_255", 32'(kb.press_cnt), 255);
    kb.key_n = 1'b0;
    step(20);
    kb.key_n = 1'b1;
    step(20);
    chk("wrap_cnt_0", 32'(kb.press_cnt), 0);
    chk("wrap_n_press", n_press - base, 256);
    chk("final_n_long", n_long, EXP_LONG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
